// File: rtl/bf16_pkg.sv
// Shared bf16 field positions, special exponent codes and class-flag bit indices.
package bf16_pkg;

  localparam int BF16_W  = 16;
  localparam int EXP_MSB = 14;
  localparam int EXP_LSB = 7;
  localparam int MAN_W   = 7;

  localparam logic [7:0]  EXP_ALL1     = 8'hFF;
  localparam logic [7:0]  EXP_ALL0     = 8'h00;
  localparam logic [14:0] BF16_MAX_MAG = 15'h7F7F;

  localparam int FLG_NAN  = 3;
  localparam int FLG_INF  = 2;
  localparam int FLG_SUB  = 1;
  localparam int FLG_ZERO = 0;

  typedef logic [3:0] bf16_flags_t;

endpackage

// File: rtl/bf16_sanitize_arbiter_rr_arbiter.sv
// Round-robin arbiter: scans from i_ptr upward (mod N) and returns a one-hot grant plus its index.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  // First requester at or after the pointer wins.
  always_comb begin
    int  w_pos;
    logic w_found;
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = 0;
    for (int k = 0; k < N; k++) begin
      w_pos = int'(i_ptr) + k;
      if (w_pos >= N) begin
        w_pos = w_pos - N;
      end else begin
        w_pos = w_pos;
      end
      if (!w_found && i_req[w_pos]) begin
        o_grant[w_pos] = 1'b1;
        o_idx          = IDX_W'(w_pos);
        w_found        = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/bf16_special_case.sv
// Combinational bf16 special-value mapping: NaN/sub/zero -> +0, Inf -> signed max-normal.
module bf16_special_case
  import bf16_pkg::*;
(
  input  logic [BF16_W-1:0] i_data,
  output logic [BF16_W-1:0] o_data
);

  logic [7:0]       w_exp;
  logic [MAN_W-1:0] w_man;

  assign w_exp = i_data[EXP_MSB:EXP_LSB];
  assign w_man = i_data[MAN_W-1:0];

  // Value mapping; -0 collapses to +0 through the all-zero exponent branch.
  always_comb begin
    o_data = i_data;
    if (w_exp == EXP_ALL1) begin
      if (w_man != 7'd0) begin
        o_data = 16'h0000;
      end else begin
        o_data = {i_data[BF16_W-1], BF16_MAX_MAG};
      end
    end else if (w_exp == EXP_ALL0) begin
      o_data = 16'h0000;
    end else begin
      o_data = i_data;
    end
  end

endmodule

// File: rtl/bf16_sanitize_arbiter.sv
// Shares one bf16 sanitizer among N_REQ producers: round-robin grant, one registered
// output stage with backpressure, id/class tagging and saturating per-class counters.
module bf16_sanitize_arbiter
  import bf16_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [BF16_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BF16_W-1:0]       out_data,
  output logic [ID_W-1:0]         out_id,
  output logic [3:0]              out_flags,
  input  logic                    cnt_clr,
  output logic [CNT_W-1:0]        nan_cnt,
  output logic [CNT_W-1:0]        inf_cnt,
  output logic [CNT_W-1:0]        sub_cnt
);

  logic              r_out_valid;
  logic [BF16_W-1:0] r_out_data;
  logic [ID_W-1:0]   r_out_id;
  bf16_flags_t       r_out_flags;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [CNT_W-1:0]  r_nan_cnt;
  logic [CNT_W-1:0]  r_inf_cnt;
  logic [CNT_W-1:0]  r_sub_cnt;

  logic              w_load_en;
  logic [N_REQ-1:0]  w_arb_req;
  logic [N_REQ-1:0]  w_grant;
  logic [ID_W-1:0]   w_idx;
  logic              w_xfer;
  logic [BF16_W-1:0] w_sel_data;
  logic [BF16_W-1:0] w_san_data;
  bf16_flags_t       w_flags;
  logic [ID_W-1:0]   w_next_ptr;
  logic [7:0]        w_exp;
  logic [MAN_W-1:0]  w_man;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Requests are masked during reset and while the output stage is full and stalled.
  assign w_load_en = !r_out_valid | out_ready;
  assign w_arb_req = (w_load_en && !rst) ? req_valid : '0;

  rr_arbiter #(.N(N_REQ), .IDX_W(ID_W)) u_arb (
    .i_req   (w_arb_req),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_xfer)
  );

  assign req_ready  = w_grant;
  assign w_sel_data = req_data[int'(w_idx)*BF16_W +: BF16_W];
  assign w_exp      = w_sel_data[EXP_MSB:EXP_LSB];
  assign w_man      = w_sel_data[MAN_W-1:0];
  assign w_next_ptr = (w_idx == ID_W'(N_REQ-1)) ? {ID_W{1'b0}} : w_idx + {{(ID_W-1){1'b0}}, 1'b1};

  bf16_special_case u_san (
    .i_data (w_sel_data),
    .o_data (w_san_data)
  );

  // Class decode of the granted operand; at most one flag set.
  always_comb begin
    w_flags           = 4'b0000;
    w_flags[FLG_NAN]  = (w_exp == EXP_ALL1) && (w_man != 7'd0);
    w_flags[FLG_INF]  = (w_exp == EXP_ALL1) && (w_man == 7'd0);
    w_flags[FLG_SUB]  = (w_exp == EXP_ALL0) && (w_man != 7'd0);
    w_flags[FLG_ZERO] = (w_exp == EXP_ALL0) && (w_man == 7'd0);
  end

  // Output stage and priority pointer; pointer only moves on a real transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= 16'h0000;
      r_out_id    <= '0;
      r_out_flags <= 4'b0000;
      r_rr_ptr    <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_san_data;
      r_out_id    <= w_idx;
      r_out_flags <= w_flags;
      r_rr_ptr    <= w_next_ptr;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  // Saturating class counters; clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_nan_cnt <= '0;
      r_inf_cnt <= '0;
      r_sub_cnt <= '0;
    end else if (w_xfer) begin
      r_nan_cnt <= w_flags[FLG_NAN] ? sat_inc(r_nan_cnt) : r_nan_cnt;
      r_inf_cnt <= w_flags[FLG_INF] ? sat_inc(r_inf_cnt) : r_inf_cnt;
      r_sub_cnt <= w_flags[FLG_SUB] ? sat_inc(r_sub_cnt) : r_sub_cnt;
    end else begin
      r_nan_cnt <= r_nan_cnt;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;
  assign out_flags = r_out_flags;
  assign nan_cnt   = r_nan_cnt;
  assign inf_cnt   = r_inf_cnt;
  assign sub_cnt   = r_sub_cnt;

endmodule
